// File: rtl/ula_pkg.sv
// Shared widths and ALU opcode encodings for the operand issue stage and the ALU.
package ula_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned ADDR_W = $clog2(NREGS);
  localparam int unsigned IMM_W  = 16;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_XOR = 4'b1101;
  localparam logic [3:0] OP_SLL = 4'b1110;
  localparam logic [3:0] OP_SRL = 4'b1111;

endpackage

// File: rtl/reg_file.sv
// 2-read 1-write register file with r0 hardwired to zero.
// REG_BYPASS_EN forwards a same-cycle write onto the read ports.
module reg_file
  import ula_pkg::*;
#(
  parameter int unsigned DW = DATA_W,
  parameter int unsigned NR = NREGS,
  parameter int unsigned AW = $clog2(NR)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          w_en,
  input  logic [AW-1:0] w_addr,
  input  logic [DW-1:0] w_data
);

  logic [DW-1:0] regs_q [NR];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NR); i++) regs_q[i] <= '0;
    end else if (w_en && (w_addr != '0)) begin
      regs_q[w_addr] <= w_data;
    end
  end

  always_comb begin
    ra_data = (ra_addr == '0) ? '0 : regs_q[ra_addr];
    rb_data = (rb_addr == '0) ? '0 : regs_q[rb_addr];
`ifdef REG_BYPASS_EN
    if (w_en && (w_addr != '0) && (w_addr == ra_addr)) ra_data = w_data;
    if (w_en && (w_addr != '0) && (w_addr == rb_addr)) rb_data = w_data;
`endif
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU issue stage: register read, immediate extension, scoreboard hazard stall and
// a registered {In1, In2, OP} bundle. REG_BYPASS_EN enables writeback forwarding.
module alu_operand_stage
  import ula_pkg::*;
#(
  parameter int unsigned DATA_W = ula_pkg::DATA_W,
  parameter int unsigned NREGS  = ula_pkg::NREGS,
  parameter int unsigned ADDR_W = $clog2(NREGS),
  parameter int unsigned IMM_W  = ula_pkg::IMM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic              in_imm_zext,
  input  logic [3:0]        in_op,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_in1,
  output logic [DATA_W-1:0] out_in2,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr_en,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  logic [DATA_W-1:0] rs_data, rt_data, imm_ext, in2_sel;
  logic [NREGS-1:0]  pending_q, pending_d, pend_eff;
  logic              hazard, issue;

  reg_file #(
    .DW (DATA_W),
    .NR (NREGS),
    .AW (ADDR_W)
  ) u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .ra_addr (in_rs),
    .ra_data (rs_data),
    .rb_addr (in_rt),
    .rb_data (rt_data),
    .w_en    (wb_en),
    .w_addr  (wb_addr),
    .w_data  (wb_data)
  );

  always_comb begin
    pend_eff = pending_q;
`ifdef REG_BYPASS_EN
    // The completing writeback is forwarded, so its register no longer blocks issue.
    if (wb_en) pend_eff[wb_addr] = 1'b0;
`endif
  end

  assign hazard   = pend_eff[in_rs] | (!in_use_imm & pend_eff[in_rt]) | (in_wr_en & pend_eff[in_rd]);
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign issue    = in_valid && in_ready;

  assign imm_ext = in_imm_zext ? {{(DATA_W-IMM_W){1'b0}}, in_imm}
                               : {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  assign in2_sel = in_use_imm ? imm_ext : rt_data;

  // Issue-side set is applied after the writeback clear so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) pending_d[wb_addr] = 1'b0;
    if (issue && in_wr_en) pending_d[in_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= '0;
      out_valid <= 1'b0;
      out_in1   <= '0;
      out_in2   <= '0;
      out_op    <= '0;
      out_rd    <= '0;
      out_wr_en <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (issue) begin
        out_valid <= 1'b1;
        out_in1   <= rs_data;
        out_in2   <= in2_sel;
        out_op    <= in_op;
        out_rd    <= in_rd;
        out_wr_en <= in_wr_en;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios plus randomized traffic checked every
// cycle against a behavioural model. Honors REG_BYPASS_EN when defined.
module tb_alu_operand_stage;
  import ula_pkg::*;

`ifdef REG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_use_imm, in_imm_zext, in_wr_en;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [3:0]  in_op;
  logic        out_valid, out_ready, out_wr_en;
  logic [31:0] out_in1, out_in2;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_ov;
  logic [31:0] m_in1, m_in2;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  bit          m_wr;

  always #5 clock = ~clock;

  alu_operand_stage dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .in_imm      (in_imm),
    .in_use_imm  (in_use_imm),
    .in_imm_zext (in_imm_zext),
    .in_op       (in_op),
    .in_wr_en    (in_wr_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_in1     (out_in1),
    .out_in2     (out_in2),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_wr_en   (out_wr_en),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // A register blocks when it is busy, unless bypass lets the current writeback release it.
  function automatic bit busy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (BYP && wb_en && wb_addr == a) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic bit model_ready();
    bit hz;
    hz = busy(in_rs) || (!in_use_imm && busy(in_rt)) || (in_wr_en && busy(in_rd));
    return !hz && (!m_ov || out_ready);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && wb_en && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_pend[i] = 1'b0;
      end
      m_ov = 1'b0;
    end else begin
      bit iss;
      iss = in_valid && model_ready();
      if (iss) begin
        m_ov  = 1'b1;
        m_in1 = model_read(in_rs);
        if (!in_use_imm)     m_in2 = model_read(in_rt);
        else if (in_imm_zext) m_in2 = {16'd0, in_imm};
        else                 m_in2 = 32'($signed(in_imm));
        m_op = in_op;
        m_rd = in_rd;
        m_wr = in_wr_en;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wb_en && wb_addr != 5'd0) begin
        m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (iss && in_wr_en && in_rd != 5'd0) m_pend[in_rd] = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (model_on) begin
      chk("model_in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
      chk("model_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      if (m_ov) begin
        chk("model_out_in1", out_in1, m_in1);
        chk("model_out_in2", out_in2, m_in2);
        chk("model_out_op", {28'd0, out_op}, {28'd0, m_op});
        chk("model_out_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("model_out_wr_en", {31'd0, out_wr_en}, {31'd0, m_wr});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [15:0] imm, input bit use_imm, input bit zext,
                           input logic [3:0] op, input bit wr);
    in_valid = 1'b1;
    in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    in_use_imm = use_imm; in_imm_zext = zext; in_op = op; in_wr_en = wr;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
    in_use_imm = 1'b0; in_imm_zext = 1'b0; in_op = '0; in_wr_en = 1'b0;
    out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    tick();
    model_on = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_in1", out_in1, 32'd0);
    chk("reset_out_in2", out_in2, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: r0 operands, one-cycle latency
    set_instr(5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, OP_ADD, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out_in1", out_in1, 32'd0);
    chk("t1_out_in2", out_in2, 32'd0);
    chk("t1_out_op", {28'd0, out_op}, 32'd2);

    // 2: writeback then immediate extension
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0005;
    tick();
    wb_en = 1'b0;
    set_instr(5'd3, 5'd0, 5'd0, 16'hFFFF, 1'b1, 1'b0, OP_ADD, 1'b0);
    tick();
    chk("t2_out_in1", out_in1, 32'h0000_0005);
    chk("t2_out_in2_sext", out_in2, 32'hFFFF_FFFF);
    set_instr(5'd0, 5'd0, 5'd0, 16'h8000, 1'b1, 1'b1, OP_OR, 1'b0);
    tick();
    chk("t2_out_in2_zext", out_in2, 32'h0000_8000);
    set_instr(5'd0, 5'd0, 5'd0, 16'h8000, 1'b1, 1'b0, OP_OR, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("t2_out_in2_sext8", out_in2, 32'hFFFF_8000);

    // 3: RAW stall on r4
    set_instr(5'd0, 5'd0, 5'd4, 16'h1, 1'b1, 1'b0, OP_ADD, 1'b1);
    tick();
    set_instr(5'd4, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, OP_AND, 1'b0);
    #1 chk("t3_raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t3_raw_stall1", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_1234;
    #1;
    if (BYP) begin
      chk("t3_bypass_ready", {31'd0, in_ready}, 32'd1);
      tick();
      wb_en = 1'b0; in_valid = 1'b0;
    end else begin
      chk("t3_wb_cycle_stall", {31'd0, in_ready}, 32'd0);
      tick();
      wb_en = 1'b0;
      #1 chk("t3_after_wb_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
    end
    chk("t3_out_in1", out_in1, 32'h0000_1234);

    // 4: backpressure holds the bundle
    set_instr(5'd3, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, OP_SUB, 1'b0);
    tick();
    out_ready = 1'b0;
    set_instr(5'd0, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, OP_SLT, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_hold_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_hold_in1", out_in1, 32'h0000_0005);
      chk("t4_hold_op", {28'd0, out_op}, {28'd0, OP_SUB});
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t4_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t4_next_op", {28'd0, out_op}, {28'd0, OP_SLT});

    // 5: WAW on r7
    set_instr(5'd0, 5'd0, 5'd7, 16'h0, 1'b1, 1'b0, OP_ADD, 1'b1);
    tick();
    #1 chk("t5_waw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("t5_waw_stall1", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0077;
    if (!BYP) begin
      #1 chk("t5_wb_cycle_stall", {31'd0, in_ready}, 32'd0);
      tick();
      wb_en = 1'b0;
    end
    #1 chk("t5_waw_ready", {31'd0, in_ready}, 32'd1);
    tick();
    wb_en = 1'b0;
    set_instr(5'd7, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, OP_AND, 1'b0);
    #1 chk("t5_r7_pending_again", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // 6: r0 ignores writes; reset during a stall
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_en = 1'b0;
    set_instr(5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 1'b0, OP_XOR, 1'b0);
    tick();
    chk("t6_r0_in1", out_in1, 32'd0);
    chk("t6_r0_in2", out_in2, 32'd0);
    set_instr(5'd0, 5'd0, 5'd9, 16'h0, 1'b1, 1'b0, OP_ADD, 1'b1);
    tick();
    set_instr(5'd9, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, OP_NOR, 1'b0);
    out_ready = 1'b0;
    #1 chk("t6_stalled", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    chk("t6_reset_out_valid", {31'd0, out_valid}, 32'd0);
    #1 chk("t6_reset_pending_clear", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_rs       = 5'($urandom_range(0, 7));
      in_rt       = 5'($urandom_range(0, 7));
      in_rd       = 5'($urandom_range(0, 7));
      in_imm      = 16'($urandom);
      in_use_imm  = 1'($urandom_range(0, 1));
      in_imm_zext = 1'($urandom_range(0, 1));
      in_op       = 4'($urandom);
      in_wr_en    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 3) != 0);
      wb_en       = ($urandom_range(0, 2) == 0);
      wb_addr     = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      tick();
    end
    in_valid = 1'b0;
    wb_en = 1'b0;
    tick();
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
